// File: rtl/spi_slave_ctrl_pkg.sv
// Shared types and helpers for the SPI mode-0 slave controller.
package spi_slave_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RW,
    ST_LOAD,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_HOLD
  } state_t;

  localparam logic SPI_RD = 1'b1;
  localparam logic SPI_WR = 1'b0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Conditioned SPI pins plus the memory-side port of the slave controller.
interface spi_slave_ctrl_if #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8
);
  logic              cs;
  logic              sclk_pe;
  logic              sclk_ne;
  logic              mosi;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              miso;
  logic              miso_oe;
  logic              busy;

  modport slave (
    input  cs, sclk_pe, sclk_ne, mosi, mem_rdata,
    output mem_addr, mem_wdata, mem_we, miso, miso_oe, busy
  );

  modport master (
    output cs, sclk_pe, sclk_ne, mosi, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, miso, miso_oe, busy
  );
endinterface

// File: rtl/spi_slave_ctrl_shift_reg.sv
// Shift register: serial-in/parallel-out with parallel load, MSB leaves first.
module spi_slave_ctrl_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic         sin,
  input  logic [W-1:0] pdata,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave: address, R/W bit, then data words with optional address auto-increment.
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter bit          BURST  = 1'b1
) (
  input logic             clk,
  input logic             reset,
  spi_slave_ctrl_if.slave bus
);

  localparam int unsigned RX_W  = max_u(ADDR_W, DATA_W);
  localparam int unsigned CNT_W = $clog2(RX_W + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               we_q, oe_q, busy_q;
  logic [RX_W-1:0]    rx_q, rx_next;
  logic [DATA_W-1:0]  tx_q;
  logic               addr_done, data_done, abort;

  logic cnt_clr, cnt_inc, rx_clr, rx_shift, addr_latch, addr_inc;
  logic wr_commit, tx_load, tx_shift, oe_set, oe_clr;

  assign addr_done = (cnt == CNT_W'(ADDR_W - 1));
  assign data_done = (cnt == CNT_W'(DATA_W - 1));
  assign abort     = (state != ST_IDLE) && bus.cs;
  // Word including the bit arriving on this sclk_pe, so a word commits on its last edge.
  assign rx_next   = {rx_q[RX_W-2:0], bus.mosi};

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (!bus.cs) state_n = ST_ADDR;
        ST_ADDR:    if (bus.sclk_pe && addr_done) state_n = ST_RW;
        ST_RW:      if (bus.sclk_pe) state_n = (bus.mosi == SPI_RD) ? ST_LOAD : ST_DATA_WR;
        ST_LOAD:    if (cnt != '0) state_n = ST_DATA_RD;
        ST_DATA_RD: if (bus.sclk_pe && data_done) state_n = BURST ? ST_LOAD : ST_HOLD;
        ST_DATA_WR: if (bus.sclk_pe && data_done && !BURST) state_n = ST_HOLD;
        default:    state_n = state;
      endcase
    end
  end

  // Datapath strobes; sclk_pe wins over sclk_ne when both arrive together.
  always_comb begin
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    rx_clr     = 1'b0;
    rx_shift   = 1'b0;
    addr_latch = 1'b0;
    addr_inc   = 1'b0;
    wr_commit  = 1'b0;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    oe_set     = 1'b0;
    oe_clr     = 1'b0;
    if (abort) begin
      cnt_clr   = 1'b1;
      oe_clr    = 1'b1;
      wr_commit = (state == ST_DATA_WR) && bus.sclk_pe && data_done;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_clr = 1'b1;
          rx_clr  = 1'b1;
        end
        ST_ADDR: if (bus.sclk_pe) begin
          rx_shift   = 1'b1;
          addr_latch = addr_done;
          cnt_clr    = addr_done;
          cnt_inc    = !addr_done;
        end
        ST_RW: if (bus.sclk_pe) begin
          cnt_clr = 1'b1;
          rx_clr  = 1'b1;
        end
        // First cycle lets mem_rdata settle on the new address, second cycle loads it.
        ST_LOAD: begin
          if (cnt == '0) begin
            cnt_inc = 1'b1;
          end else begin
            tx_load = 1'b1;
            oe_set  = 1'b1;
            cnt_clr = 1'b1;
          end
        end
        ST_DATA_RD: begin
          if (bus.sclk_pe) begin
            cnt_clr  = data_done;
            cnt_inc  = !data_done;
            addr_inc = data_done && BURST;
            oe_clr   = data_done && !BURST;
          end else if (bus.sclk_ne && cnt != '0) begin
            tx_shift = 1'b1;
          end
        end
        ST_DATA_WR: begin
          addr_inc = BURST && we_q;
          if (bus.sclk_pe) begin
            rx_shift  = 1'b1;
            wr_commit = data_done;
            cnt_clr   = data_done;
            cnt_inc   = !data_done;
          end
        end
        ST_HOLD: oe_clr = 1'b1;
        default: oe_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      we_q   <= wr_commit;
      busy_q <= (state_n != ST_IDLE);
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (addr_latch)    addr_q <= rx_next[ADDR_W-1:0];
      else if (addr_inc) addr_q <= addr_q + ADDR_W'(1);
      if (wr_commit) wdata_q <= rx_next[DATA_W-1:0];
      if (oe_clr)      oe_q <= 1'b0;
      else if (oe_set) oe_q <= 1'b1;
    end
  end

  spi_slave_ctrl_shift_reg #(.W(RX_W)) u_rx (
    .clk   (clk),
    .reset (reset),
    .clr   (rx_clr),
    .load  (1'b0),
    .shift (rx_shift),
    .sin   (bus.mosi),
    .pdata ({RX_W{1'b0}}),
    .q     (rx_q)
  );

  spi_slave_ctrl_shift_reg #(.W(DATA_W)) u_tx (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .load  (tx_load),
    .shift (tx_shift),
    .sin   (1'b0),
    .pdata (bus.mem_rdata),
    .q     (tx_q)
  );

  // Bits that only matter inside the shift registers themselves.
  logic unused_bits;
  assign unused_bits = ^{rx_q[RX_W-1], tx_q[DATA_W-2:0]};

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = we_q;
  assign bus.miso      = tx_q[DATA_W-1];
  assign bus.miso_oe   = oe_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Scoreboard bench: three controller configurations share the SPI stimulus lines.
module tb_spi_slave_ctrl;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic [31:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, pe, ne, mosi;
  logic [2:0] cs;
  int         vectors = 0;
  int         miscompares = 0;
  int         oe_viol = 0;
  bit         oe_watch = 1'b0;
  ev_t        exp0[$], exp1[$], exp2[$];

  always #5 clk = ~clk;

  spi_slave_ctrl_if #(.ADDR_W(7),  .DATA_W(8))  if0 ();
  spi_slave_ctrl_if #(.ADDR_W(7),  .DATA_W(8))  if1 ();
  spi_slave_ctrl_if #(.ADDR_W(10), .DATA_W(16)) if2 ();

  assign if0.cs = cs[0];  assign if0.sclk_pe = pe;  assign if0.sclk_ne = ne;  assign if0.mosi = mosi;
  assign if1.cs = cs[1];  assign if1.sclk_pe = pe;  assign if1.sclk_ne = ne;  assign if1.mosi = mosi;
  assign if2.cs = cs[2];  assign if2.sclk_pe = pe;  assign if2.sclk_ne = ne;  assign if2.mosi = mosi;

  spi_slave_ctrl #(.ADDR_W(7),  .DATA_W(8),  .BURST(1'b1)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  spi_slave_ctrl #(.ADDR_W(7),  .DATA_W(8),  .BURST(1'b0)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  spi_slave_ctrl #(.ADDR_W(10), .DATA_W(16), .BURST(1'b1)) u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  // Memories with one-cycle registered read.
  logic [7:0]  mem0 [128];
  logic [7:0]  mem1 [128];
  logic [15:0] mem2 [1024];
  initial begin
    for (int i = 0; i < 128; i++) begin mem0[i] = 8'h00; mem1[i] = 8'h00; end
    for (int i = 0; i < 1024; i++) mem2[i] = 16'h0000;
  end
  always @(posedge clk) begin
    if (if0.mem_we) mem0[if0.mem_addr] <= if0.mem_wdata;
    if (if1.mem_we) mem1[if1.mem_addr] <= if1.mem_wdata;
    if (if2.mem_we) mem2[if2.mem_addr] <= if2.mem_wdata;
    if0.mem_rdata <= mem0[if0.mem_addr];
    if1.mem_rdata <= mem1[if1.mem_addr];
    if2.mem_rdata <= mem2[if2.mem_addr];
  end

  function automatic ev_t mk(input logic rd, input logic [15:0] a, input logic [31:0] d);
    ev_t e;
    e.rd = rd; e.addr = a; e.data = d;
    return e;
  endfunction

  task automatic push(input int k, input ev_t e);
    case (k)
      0: exp0.push_back(e);
      1: exp1.push_back(e);
      default: exp2.push_back(e);
    endcase
  endtask

  task automatic check_ev(input int k, input ev_t got, input string tag);
    ev_t want;
    bit  empty;
    vectors++;
    case (k)
      0: empty = (exp0.size() == 0);
      1: empty = (exp1.size() == 0);
      default: empty = (exp2.size() == 0);
    endcase
    if (empty) begin
      miscompares++;
      $display("FAIL dut%0d %s unexpected: rd=%0b addr=%h data=%h", k, tag, got.rd, got.addr, got.data);
    end else begin
      case (k)
        0: want = exp0.pop_front();
        1: want = exp1.pop_front();
        default: want = exp2.pop_front();
      endcase
      if (got !== want) begin
        miscompares++;
        $display("FAIL dut%0d %s: got rd=%0b addr=%h data=%h, want rd=%0b addr=%h data=%h",
                 k, tag, got.rd, got.addr, got.data, want.rd, want.addr, want.data);
      end
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Monitors: memory writes and completed MISO words, sampled mid-cycle.
  logic [31:0] rsh0, rsh1, rsh2;
  int          rn0 = 0, rn1 = 0, rn2 = 0;
  always @(negedge clk) begin
    if (oe_watch && (if0.miso_oe || if1.miso_oe || if2.miso_oe)) oe_viol++;
    if (if0.mem_we) check_ev(0, mk(1'b0, 16'(if0.mem_addr), 32'(if0.mem_wdata)), "write");
    if (if1.mem_we) check_ev(1, mk(1'b0, 16'(if1.mem_addr), 32'(if1.mem_wdata)), "write");
    if (if2.mem_we) check_ev(2, mk(1'b0, 16'(if2.mem_addr), 32'(if2.mem_wdata)), "write");
    if (if0.cs || reset) rn0 = 0;
    else if (if0.sclk_pe && if0.miso_oe) begin
      rsh0 = ((rn0 == 0) ? 32'd0 : (rsh0 << 1)) | 32'(if0.miso);
      rn0++;
      if (rn0 == 8) begin check_ev(0, mk(1'b1, 16'(if0.mem_addr), rsh0), "read"); rn0 = 0; end
    end
    if (if1.cs || reset) rn1 = 0;
    else if (if1.sclk_pe && if1.miso_oe) begin
      rsh1 = ((rn1 == 0) ? 32'd0 : (rsh1 << 1)) | 32'(if1.miso);
      rn1++;
      if (rn1 == 8) begin check_ev(1, mk(1'b1, 16'(if1.mem_addr), rsh1), "read"); rn1 = 0; end
    end
    if (if2.cs || reset) rn2 = 0;
    else if (if2.sclk_pe && if2.miso_oe) begin
      rsh2 = ((rn2 == 0) ? 32'd0 : (rsh2 << 1)) | 32'(if2.miso);
      rn2++;
      if (rn2 == 16) begin check_ev(2, mk(1'b1, 16'(if2.mem_addr), rsh2), "read"); rn2 = 0; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sclk period: 8 clocks, rising edge pulse then falling edge pulse.
  task automatic sbit(input logic b, input logic both);
    mosi = b;
    tick(2);
    pe = 1'b1; ne = both;
    tick(1);
    pe = 1'b0; ne = 1'b0;
    tick(3);
    ne = 1'b1;
    tick(1);
    ne = 1'b0;
    tick(1);
  endtask

  task automatic send(input logic [31:0] val, input int n, input logic [31:0] both_mask);
    for (int i = n - 1; i >= 0; i--) sbit(val[i], both_mask[i]);
  endtask

  task automatic start(input int k);
    cs[k] = 1'b0;
    tick(2);
  endtask

  task automatic stop(input int k);
    tick(2);
    cs[k] = 1'b1;
    tick(3);
  endtask

  task automatic check_zero0(input string tag);
    check_val({tag, " mem_addr"},  32'(if0.mem_addr),  32'h0);
    check_val({tag, " mem_wdata"}, 32'(if0.mem_wdata), 32'h0);
    check_val({tag, " mem_we"},    32'(if0.mem_we),    32'h0);
    check_val({tag, " miso"},      32'(if0.miso),      32'h0);
    check_val({tag, " miso_oe"},   32'(if0.miso_oe),   32'h0);
    check_val({tag, " busy"},      32'(if0.busy),      32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cs = 3'b111; pe = 1'b0; ne = 1'b0; mosi = 1'b0;
    tick(3);
    check_zero0("reset");
    check_val("reset dut2 busy", 32'(if2.busy), 32'h0);
    reset = 1'b0;
    tick(2);

    // Single write; MISO stays disabled.
    push(0, mk(1'b0, 16'h15, 32'hA5));
    oe_watch = 1'b1;
    start(0); send(32'h15, 7, 0); send(0, 1, 0); send(32'hA5, 8, 0);
    check_val("write busy", 32'(if0.busy), 32'h1);
    stop(0);
    oe_watch = 1'b0;
    check_val("write miso_oe", 32'(oe_viol), 32'h0);
    check_val("write addr post-burst", 32'(if0.mem_addr), 32'h16);

    // Single read of the word just written.
    push(0, mk(1'b1, 16'h15, 32'hA5));
    start(0); send(32'h15, 7, 0); send(1, 1, 0); send(0, 8, 0); stop(0);

    // Burst write across the address wrap.
    push(0, mk(1'b0, 16'h7E, 32'h11));
    push(0, mk(1'b0, 16'h7F, 32'h22));
    push(0, mk(1'b0, 16'h00, 32'h33));
    start(0); send(32'h7E, 7, 0); send(0, 1, 0);
    send(32'h11, 8, 0); send(32'h22, 8, 0); send(32'h33, 8, 0);
    stop(0);

    // Read with a simultaneous sclk_pe/sclk_ne on the fourth bit.
    push(0, mk(1'b1, 16'h7F, 32'h22));
    start(0); send(32'h7F, 7, 0); send(1, 1, 0); send(0, 8, 32'h10); stop(0);

    // Abort after 5 data bits, then a clean frame.
    start(0); send(32'h20, 7, 0); send(0, 1, 0); send(32'h16, 5, 0);
    cs[0] = 1'b1;
    tick(1);
    check_val("abort busy", 32'(if0.busy), 32'h0);
    check_val("abort addr", 32'(if0.mem_addr), 32'h20);
    tick(3);
    push(0, mk(1'b0, 16'h21, 32'h5A));
    start(0); send(32'h21, 7, 0); send(0, 1, 0); send(32'h5A, 8, 0); stop(0);

    // cs rises on the same clock as the final write bit.
    push(0, mk(1'b0, 16'h30, 32'hC3));
    start(0); send(32'h30, 7, 0); send(0, 1, 0); send(32'h61, 7, 0);
    mosi = 1'b1;
    tick(2);
    pe = 1'b1; cs[0] = 1'b1;
    tick(1);
    pe = 1'b0;
    tick(1);
    check_val("csrise busy", 32'(if0.busy), 32'h0);
    tick(2);
    check_val("csrise addr", 32'(if0.mem_addr), 32'h30);

    // Single-word configuration: write, read, then trailing clocks are ignored.
    push(1, mk(1'b0, 16'h05, 32'h3C));
    start(1); send(32'h05, 7, 0); send(0, 1, 0); send(32'h3C, 8, 0);
    check_val("hold busy", 32'(if1.busy), 32'h1);
    stop(1);
    push(1, mk(1'b1, 16'h05, 32'h3C));
    start(1); send(32'h05, 7, 0); send(1, 1, 0); send(0, 8, 0);
    oe_watch = 1'b1;
    send(32'hFFFF, 16, 0);
    oe_watch = 1'b0;
    check_val("hold miso_oe", 32'(oe_viol), 32'h0);
    check_val("hold addr", 32'(if1.mem_addr), 32'h05);
    stop(1);

    // Reset in the middle of a read.
    start(0); send(32'h15, 7, 0); send(1, 1, 0); send(0, 3, 0);
    reset = 1'b1;
    tick(1);
    check_zero0("midreset");
    cs[0] = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(2);

    // Wide configuration: burst write then burst read across the wrap.
    push(2, mk(1'b0, 16'h3FF, 32'hBEEF));
    push(2, mk(1'b0, 16'h000, 32'h1234));
    start(2); send(32'h3FF, 10, 0); send(0, 1, 0); send(32'hBEEF, 16, 0); send(32'h1234, 16, 0); stop(2);
    push(2, mk(1'b1, 16'h3FF, 32'hBEEF));
    push(2, mk(1'b1, 16'h000, 32'h1234));
    start(2); send(32'h3FF, 10, 0); send(1, 1, 0); send(0, 32, 0); stop(2);

    tick(4);
    check_val("dut0 pending", 32'(exp0.size()), 32'h0);
    check_val("dut1 pending", 32'(exp1.size()), 32'h0);
    check_val("dut2 pending", 32'(exp2.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
